// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_cfg
// Purpose  : Parametrised SPI master. Each accepted start sends one frame in
//            one of the four CPOL/CPHA modes and captures MISO at the same
//            time (full duplex). A start/busy/done handshake frames the
//            transfer, and a bits-remaining counter is exposed.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W     frame width in bits (2..32)
//   DIV        clk cycles per SCLK half-period (>=1)
//   MSB_FIRST  1 = MSB shifted first, 0 = LSB shifted first
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   transfer request, sampled only in IDLE
//   mode       in   {CPOL,CPHA}, latched when start is accepted
//   tx_data    in   frame to send, latched when start is accepted
//   spi_miso   in   serial data from slave
//   loopback   in   (SPI_LOOPBACK_EN only) sample MOSI instead of MISO
//   busy       out  high from the cycle after acceptance until done
//   done       out  one-cycle completion pulse
//   rx_data    out  captured frame, updated with done and held
//   spi_cs     out  active-low chip select
//   spi_sclk   out  serial clock
//   spi_mosi   out  serial data to slave
//   bit_cnt    out  bits remaining in the current frame
// Build option
//   SPI_LOOPBACK_EN  adds the loopback input and the sampling mux
// ============================================================================
module spi_master_cfg #(
   parameter int DATA_W    = 16,
   parameter int DIV       = 2,
   parameter int MSB_FIRST = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [1:0]                   mode,
   input  logic [DATA_W-1:0]            tx_data,
   input  logic                         spi_miso,
`ifdef SPI_LOOPBACK_EN
   input  logic                         loopback,
`endif
   output logic                         busy,
   output logic                         done,
   output logic [DATA_W-1:0]            rx_data,
   output logic                         spi_cs,
   output logic                         spi_sclk,
   output logic                         spi_mosi,
   output logic [$clog2(DATA_W+1)-1:0]  bit_cnt
);

   localparam int c_CNT_W  = $clog2(DATA_W + 1);
   localparam int c_EDGE_W = $clog2(2 * DATA_W + 1);
   localparam int c_DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(DIV - 1);
   localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(2 * DATA_W - 1);
   localparam logic [c_EDGE_W-1:0] c_EDGE_ONE  = c_EDGE_W'(1);
   localparam logic [c_DIV_W-1:0]  c_DIV_ONE   = c_DIV_W'(1);
   localparam logic [c_CNT_W-1:0]  c_BITS      = c_CNT_W'(DATA_W);
   localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_XFER  = 2'd1,
      S_TRAIL = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Bit-order helpers: the transmit word is consumed from its "head"
   // end, the receive word is filled from the opposite end so that the
   // first bit on the wire lands in the same position it left from.
   // ------------------------------------------------------------------
   function automatic logic head_bit(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
   endfunction

   function automatic logic [DATA_W-1:0] drop_head(input logic [DATA_W-1:0] v);
      return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
   endfunction

   function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] v,
                                                  input logic              b);
      return (MSB_FIRST != 0) ? {v[DATA_W-2:0], b} : {b, v[DATA_W-1:1]};
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                state_q,    state_d;
   logic [c_DIV_W-1:0]    div_cnt_q,  div_cnt_d;
   logic [c_EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
   logic                  cpol_q,     cpol_d;
   logic                  cpha_q,     cpha_d;
   logic [DATA_W-1:0]     tx_sh_q,    tx_sh_d;
   logic [DATA_W-1:0]     rx_sh_q,    rx_sh_d;
   logic [DATA_W-1:0]     rx_data_q,  rx_data_d;
   logic [c_CNT_W-1:0]    bit_cnt_q,  bit_cnt_d;
   logic                  busy_q,     busy_d;
   logic                  done_q,     done_d;
   logic                  cs_q,       cs_d;
   logic                  sclk_q,     sclk_d;
   logic                  mosi_q,     mosi_d;

   logic                  w_rx_in;
   logic                  w_tick;
   logic                  w_lead;
   logic                  w_last;
   logic                  w_sample;

`ifdef SPI_LOOPBACK_EN
   // Loopback taps the registered MOSI; it is stable across every sampling
   // edge, so the captured frame equals the transmitted one.
   assign w_rx_in = loopback ? mosi_q : spi_miso;
`else
   assign w_rx_in = spi_miso;
`endif

   // Half-period expiry, and the classification of the toggle about to be
   // issued: toggle number edge_cnt_q+1, odd = leading, last = 2*DATA_W.
   assign w_tick   = (div_cnt_q == c_DIV_LAST);
   assign w_lead   = ~edge_cnt_q[0];
   assign w_last   = (edge_cnt_q == c_EDGE_LAST);
   // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
   assign w_sample = w_lead ^ cpha_q;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         div_cnt_q  <= '0;
         edge_cnt_q <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         bit_cnt_q  <= c_BITS;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cs_q       <= 1'b1;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         bit_cnt_q  <= bit_cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cs_q       <= cs_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      div_cnt_d  = div_cnt_q;
      edge_cnt_d = edge_cnt_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      bit_cnt_d  = bit_cnt_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      cs_d       = cs_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;

      case (state_q)
         S_IDLE: begin
            cs_d       = 1'b1;
            busy_d     = 1'b0;
            sclk_d     = cpol_q;
            bit_cnt_d  = c_BITS;
            div_cnt_d  = '0;
            edge_cnt_d = '0;
            if (start) begin
               state_d = S_XFER;
               cpol_d  = mode[1];
               cpha_d  = mode[0];
               sclk_d  = mode[1];
               cs_d    = 1'b0;
               busy_d  = 1'b1;
               rx_sh_d = '0;
               if (!mode[0]) begin
                  // CPHA=0: first bit must be on the line before the
                  // first (sampling) edge.
                  mosi_d  = head_bit(tx_data);
                  tx_sh_d = drop_head(tx_data);
               end else begin
                  tx_sh_d = tx_data;
               end
            end
         end

         S_XFER: begin
            if (w_tick) begin
               div_cnt_d  = '0;
               edge_cnt_d = edge_cnt_q + c_EDGE_ONE;
               sclk_d     = ~sclk_q;
               if (w_sample) begin
                  rx_sh_d   = push_bit(rx_sh_q, w_rx_in);
                  bit_cnt_d = bit_cnt_q - c_CNT_ONE;
               end else if (!w_last) begin
                  // Only CPHA=0 reaches the final edge as a non-sampling
                  // edge; there is no bit left to shift there.
                  mosi_d  = head_bit(tx_sh_q);
                  tx_sh_d = drop_head(tx_sh_q);
               end
               if (w_last) begin
                  state_d = S_TRAIL;
               end
            end else begin
               div_cnt_d = div_cnt_q + c_DIV_ONE;
            end
         end

         S_TRAIL: begin
            // SCLK already rests at CPOL after an even number of toggles;
            // hold CS low for one more half-period.
            if (w_tick) begin
               state_d    = S_IDLE;
               div_cnt_d  = '0;
               edge_cnt_d = '0;
               cs_d       = 1'b1;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               rx_data_d  = rx_sh_q;
               bit_cnt_d  = c_BITS;
            end else begin
               div_cnt_d = div_cnt_q + c_DIV_ONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign rx_data  = rx_data_q;
   assign spi_cs   = cs_q;
   assign spi_sclk = sclk_q;
   assign spi_mosi = mosi_q;
   assign bit_cnt  = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_cfg
// Purpose  : Self-checking bench for spi_master_cfg. Two instances are used:
//            16-bit / DIV=2 / MSB first, and 8-bit / DIV=1 / LSB first.
//            A pin-level SPI slave answers with a chosen word and records
//            what it receives on MOSI.
// Revision : 1.0 - initial release
// Build option: SPI_LOOPBACK_EN adds the loopback scenario.
// ============================================================================
module tb_spi_master_cfg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        spi_miso = 1'b0;

   logic        start16 = 1'b0;
   logic [1:0]  mode16  = 2'b00;
   logic [15:0] tx16    = '0;
   logic        busy16, done16, cs16, sclk16, mosi16;
   logic [15:0] rx16;
   logic [4:0]  bc16;

   logic        start8 = 1'b0;
   logic [1:0]  mode8  = 2'b00;
   logic [7:0]  tx8    = '0;
   logic        busy8, done8, cs8, sclk8, mosi8;
   logic [7:0]  rx8;
   logic [3:0]  bc8;

`ifdef SPI_LOOPBACK_EN
   logic        lb16 = 1'b0;
   logic        lb8  = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int n_done16 = 0;
   int n_done8  = 0;

   always #5 clk = ~clk;

   spi_master_cfg #(.DATA_W(16), .DIV(2), .MSB_FIRST(1)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .mode(mode16), .tx_data(tx16),
      .spi_miso(spi_miso),
`ifdef SPI_LOOPBACK_EN
      .loopback(lb16),
`endif
      .busy(busy16), .done(done16), .rx_data(rx16), .spi_cs(cs16),
      .spi_sclk(sclk16), .spi_mosi(mosi16), .bit_cnt(bc16)
   );

   spi_master_cfg #(.DATA_W(8), .DIV(1), .MSB_FIRST(0)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .mode(mode8), .tx_data(tx8),
      .spi_miso(spi_miso),
`ifdef SPI_LOOPBACK_EN
      .loopback(lb8),
`endif
      .busy(busy8), .done(done8), .rx_data(rx8), .spi_cs(cs8),
      .spi_sclk(sclk8), .spi_mosi(mosi8), .bit_cnt(bc8)
   );

   // ------------------------------------------------------------------
   // View of the instance currently attached to the slave
   // ------------------------------------------------------------------
   logic        sel = 1'b0;          // 0: 16-bit instance, 1: 8-bit instance
   wire         o_cs   = sel ? cs8   : cs16;
   wire         o_sclk = sel ? sclk8 : sclk16;
   wire         o_mosi = sel ? mosi8 : mosi16;
   wire         o_busy = sel ? busy8 : busy16;
   wire         o_done = sel ? done8 : done16;
   wire [31:0]  o_rx   = sel ? {24'b0, rx8} : {16'b0, rx16};
   wire [31:0]  o_bc   = sel ? {28'b0, bc8} : {27'b0, bc16};

   always @(negedge clk) begin
      if (done16) n_done16++;
      if (done8)  n_done8++;
   end

   // ------------------------------------------------------------------
   // SPI slave, evaluated once per clk on the falling edge. It reacts to
   // observed pin changes only: leading edge = SCLK moving away from CPOL.
   // ------------------------------------------------------------------
   logic        s_cpol = 1'b0, s_cpha = 1'b0, s_mute = 1'b0;
   logic [31:0] s_tx_word = '0;      // word the slave sends
   logic [31:0] s_rx_word = '0;      // word the slave received on MOSI
   int          s_lead = 0, s_trail = 0, s_out_idx = 0, s_in_idx = 0;
   logic        s_in_frame = 1'b0;
   logic        p_cs = 1'b1, p_sclk = 1'b0;

   function automatic int bit_pos(input int j, input int n, input logic lsb_first);
      return lsb_first ? j : (n - 1 - j);
   endfunction

   always @(negedge clk) begin
      int  n;
      logic lead;
      n = sel ? 8 : 16;
      if (o_cs) begin
         s_in_frame = 1'b0;
      end else if (p_cs) begin
         s_in_frame = 1'b1;
         s_out_idx  = 0;
         s_in_idx   = 0;
         s_rx_word  = '0;
         s_lead     = 0;
         s_trail    = 0;
         if (!s_cpha) begin
            spi_miso  = s_mute ? 1'b0 : s_tx_word[bit_pos(0, n, sel)];
            s_out_idx = 1;
         end
      end else if (s_in_frame && (o_sclk !== p_sclk)) begin
         lead = (o_sclk != s_cpol);
         if (lead) s_lead++; else s_trail++;
         if (lead != s_cpha) begin
            if (s_in_idx < n) s_rx_word[bit_pos(s_in_idx, n, sel)] = o_mosi;
            s_in_idx++;
         end else if (s_out_idx < n) begin
            spi_miso = s_mute ? 1'b0 : s_tx_word[bit_pos(s_out_idx, n, sel)];
            s_out_idx++;
         end
      end
      p_cs   = o_cs;
      p_sclk = o_sclk;
   end

   // ------------------------------------------------------------------
   // Checking helpers
   // ------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transfer on the selected instance with full checking.
   task automatic run_xfer(input logic which, input logic [1:0] m,
                           input logic [31:0] tx_in, input logic [31:0] resp_in,
                           input string tag);
      logic [31:0] mask, tx, resp, bc_prev;
      int          n, exp_lat, lat;
      n       = which ? 8 : 16;
      mask    = which ? 32'h0000_00FF : 32'h0000_FFFF;
      tx      = tx_in & mask;
      resp    = resp_in & mask;
      exp_lat = which ? (1 + (2 * 8 + 1) * 1) : (1 + (2 * 16 + 1) * 2);
      sel       = which;
      s_cpol    = m[1];
      s_cpha    = m[0];
      s_tx_word = resp;
      @(negedge clk);
      if (which) begin start8 = 1'b1; mode8 = m; tx8 = tx[7:0]; end
      else begin start16 = 1'b1; mode16 = m; tx16 = tx[15:0]; end
      @(negedge clk);                          // cycle 1
      start8 = 1'b0; start16 = 1'b0;
      // Inputs changing mid-transfer must have no effect.
      mode8 = ~m; tx8 = ~tx8; mode16 = ~m; tx16 = ~tx16;
      lat = 1;
      check({tag, "_cs_c1"}, {31'b0, o_cs}, 32'd0);
      check({tag, "_busy_c1"}, {31'b0, o_busy}, 32'd1);
      if (!m[0]) check({tag, "_mosi_c1"}, {31'b0, o_mosi}, {31'b0, tx[n-1-((which) ? n-1 : 0)]});
      bc_prev = o_bc;
      while (!o_done && lat < 400) begin
         bc_prev = o_bc;
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_rx"}, o_rx, resp);
      check({tag, "_mosi_word"}, s_rx_word, tx);
      check({tag, "_lead_edges"}, s_lead, n);
      check({tag, "_trail_edges"}, s_trail, n);
      check({tag, "_cnt_end"}, bc_prev, 32'd0);
      check({tag, "_cnt_idle"}, o_bc, n);
      check({tag, "_sclk_idle"}, {31'b0, o_sclk}, {31'b0, m[1]});
      check({tag, "_cs_done"}, {31'b0, o_cs}, 32'd1);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'b0, o_done}, 32'd0);
   endtask

   // ------------------------------------------------------------------
   // Directed + randomized sequence
   // ------------------------------------------------------------------
   initial begin
      int d_base, lat;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_cs",   {31'b0, cs16},   32'd1);
      check("rst_sclk", {31'b0, sclk16}, 32'd0);
      check("rst_mosi", {31'b0, mosi16}, 32'd0);
      check("rst_busy", {31'b0, busy16}, 32'd0);
      check("rst_done", {31'b0, done16}, 32'd0);
      check("rst_rx",   {16'b0, rx16},   32'd0);
      check("rst_cnt",  {27'b0, bc16},   32'd16);
      check("rst_cnt8", {28'b0, bc8},    32'd8);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Mode 0 reference frame
      run_xfer(1'b0, 2'b00, 32'hA5C3, 32'h3C5A, "m0");
      // Remaining modes, echo slave
      run_xfer(1'b0, 2'b01, 32'h8001, 32'h8001, "m1");
      run_xfer(1'b0, 2'b10, 32'h8001, 32'h8001, "m2");
      run_xfer(1'b0, 2'b11, 32'h8001, 32'h8001, "m3");

      // Back-to-back: start held through the done cycle
      sel = 1'b0; s_cpol = 1'b0; s_cpha = 1'b0; s_tx_word = 32'h1234;
      d_base = n_done16;
      @(negedge clk);
      start16 = 1'b1; mode16 = 2'b00; tx16 = 16'h0F0F;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!done16 && lat < 400);
      check("b2b_lat1",     lat, 32'd67);
      check("b2b_rx1",      {16'b0, rx16}, 32'h1234);
      check("b2b_mosi1",    s_rx_word, 32'h0F0F);
      check("b2b_cs_done",  {31'b0, cs16}, 32'd1);
      tx16 = 16'hF00D; s_tx_word = 32'h4321;
      @(negedge clk);
      lat = 1;
      check("b2b_cs_gap",   {31'b0, cs16}, 32'd0);
      start16 = 1'b0;
      repeat (10) begin @(negedge clk); lat++; end
      start16 = 1'b1; mode16 = 2'b11; tx16 = 16'hDEAD;   // ignored while busy
      @(negedge clk); lat++;
      start16 = 1'b0;
      while (!done16 && lat < 400) begin @(negedge clk); lat++; end
      check("b2b_lat2",     lat, 32'd67);
      check("b2b_rx2",      {16'b0, rx16}, 32'h4321);
      check("b2b_mosi2",    s_rx_word, 32'hF00D);
      repeat (80) @(negedge clk);
      check("b2b_dones",    n_done16 - d_base, 32'd2);
      check("b2b_idle_cs",  {31'b0, cs16}, 32'd1);

      // Reset in the middle of a frame (CPOL=1 so the SCLK reset is visible)
      s_cpol = 1'b1; s_cpha = 1'b0; s_tx_word = 32'hFFFF;
      d_base = n_done16;
      @(negedge clk);
      start16 = 1'b1; mode16 = 2'b10; tx16 = 16'hFFFF;
      @(negedge clk);                          // cycle 1
      start16 = 1'b0;
      repeat (19) @(negedge clk);              // cycle 20
      rst = 1'b1;
      @(negedge clk);                          // cycle 21
      check("mrst_cs",   {31'b0, cs16},   32'd1);
      check("mrst_sclk", {31'b0, sclk16}, 32'd0);
      check("mrst_busy", {31'b0, busy16}, 32'd0);
      check("mrst_cnt",  {27'b0, bc16},   32'd16);
      check("mrst_rx",   {16'b0, rx16},   32'd0);
      rst = 1'b0;
      repeat (80) @(negedge clk);
      check("mrst_no_done", n_done16 - d_base, 32'd0);
      run_xfer(1'b0, 2'b00, 32'h5A5A, 32'hC001, "mrst_after");

      // LSB-first, 8-bit, DIV=1
      run_xfer(1'b1, 2'b00, 32'h01, 32'h96, "lsb8");

      // Randomized transfers
      for (int i = 0; i < 6; i++)
         run_xfer(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, "rnd16");
      for (int i = 0; i < 4; i++)
         run_xfer(1'b1, 2'($urandom_range(0, 3)), $urandom, $urandom, "rnd8");

`ifdef SPI_LOOPBACK_EN
      lb16 = 1'b1; s_mute = 1'b1;
      run_xfer(1'b0, 2'b00, 32'hBEEF, 32'hBEEF, "loop_m0");
      run_xfer(1'b0, 2'b11, 32'h1357, 32'h1357, "loop_m3");
      lb16 = 1'b0; s_mute = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
